// File: rtl/yarp_pkg.sv
// rtl/yarp_pkg.sv - shared fetch types and constants for the yarp core
package yarp_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/yarp_instr_buf.sv
// rtl/yarp_instr_buf.sv - single-entry valid/ready holding register with synchronous flush
module yarp_instr_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_tvalid,
  input  logic [63:0] in_tdata,
  output logic        out_tvalid,
  output logic [63:0] out_tdata,
  input  logic        out_tready
);

  // A flush wins over a same-cycle load so a wrong-path response never lands
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
    end else if (flush) begin
      out_tvalid <= 1'b0;
    end else if (in_tvalid) begin
      out_tvalid <= 1'b1;
      out_tdata  <= in_tdata;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/yarp_fetch_ctrl.sv
// rtl/yarp_fetch_ctrl.sv - PC owner and one-outstanding instruction fetch with branch redirect
// Optional misaligned-target trap enabled by YARP_FETCH_MISALIGN_CHK_EN.
module yarp_fetch_ctrl
  import yarp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        dec_ready_i,
  output logic        fetch_misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  logic         misalign_q;
  logic         buf_load;
  logic [31:0]  redirect_pc;
  logic         misaligned;

`ifdef YARP_FETCH_MISALIGN_CHK_EN
  assign redirect_pc = branch_target_i;
  assign misaligned  = branch_taken_i && (branch_target_i[1:0] != 2'b00);
`else
  assign redirect_pc = branch_target_i & ~32'h3;
  assign misaligned  = 1'b0;
`endif

  // Only issue when the single buffer entry will be free, so responses never stall
  assign imem_req_o  = reset_n && (state_q == REQ) && (!instr_valid_o || dec_ready_i);
  assign imem_addr_o = pc_q;
  assign fetch_misalign_o = misalign_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    buf_load = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_req_o && imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'(INSTR_BYTES);
          kill_d   = branch_taken_i;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          buf_load = !kill_q && !branch_taken_i;
          kill_d   = 1'b0;
          state_d  = REQ;
        end else if (branch_taken_i) begin
          kill_d = 1'b1;
        end
      end
      default: kill_d = 1'b0;
    endcase
    // Redirect overrides the sequential PC; a misaligned target traps instead
    if (branch_taken_i) begin
      if (misaligned) begin
        pc_d    = pc_q;
        kill_d  = 1'b0;
        state_d = ERR;
      end else begin
        pc_d = redirect_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      misalign_q <= misaligned && (state_q != ERR);
    end
  end

  yarp_instr_buf u_instr_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (branch_taken_i),
    .in_tvalid  (buf_load),
    .in_tdata   ({imem_rdata_i, req_pc_q}),
    .out_tvalid (instr_valid_o),
    .out_tdata  ({instr_o, instr_pc_o}),
    .out_tready (dec_ready_i)
  );

endmodule

// File: tb/tb_yarp_fetch_ctrl.sv
// tb/tb_yarp_fetch_ctrl.sv - directed self-checking bench for yarp_fetch_ctrl
module tb_yarp_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        dec_ready_i;
  logic        fetch_misalign_o;

  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          cnt;
  bit          pend;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  yarp_fetch_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .dec_ready_i      (dec_ready_i),
    .fetch_misalign_o (fetch_misalign_o)
  );

  // One clock; memory answers each grant after lat cycles with data = addr + 0x5000_0000
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = imem_req_o & imem_gnt_i;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    if (g) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = paddr + 32'h5000_0000;
        pend          = 1'b0;
      end else begin
        imem_rvalid_i = 1'b0;
      end
    end else begin
      imem_rvalid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    imem_gnt_i      = 1'b0;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = 32'h0;
    dec_ready_i     = 1'b1;
    lat             = 1;
    pend            = 1'b0;
    cnt             = 0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    imem_gnt_i      = 1'b1;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = 32'h0;
    dec_ready_i     = 1'b1;
    lat             = 1;
    pend            = 1'b0;
    tick();
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h1000) begin errors++; $display("FAIL rst_addr got=%h exp=00001000", imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", instr_pc_o); end
    checks++; if (fetch_misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign_o); end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_gnt_i = 1'b1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin errors++; $display("FAIL seq_req0 got=%b/%h exp=1/00001000", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL seq_wait_req got=%b exp=0", imem_req_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000 || instr_o !== 32'h5000_1000) begin errors++; $display("FAIL seq_instr0 got=%b/%h/%h exp=1/00001000/50001000", instr_valid_o, instr_pc_o, instr_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1004) begin errors++; $display("FAIL seq_req1 got=%b/%h exp=1/00001004", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL seq_pop got=%b exp=0", instr_valid_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1004 || instr_o !== 32'h5000_1004) begin errors++; $display("FAIL seq_instr1 got=%b/%h/%h exp=1/00001004/50001004", instr_valid_o, instr_pc_o, instr_o); end
    checks++; if (imem_addr_o !== 32'h1008) begin errors++; $display("FAIL seq_req2 got=%h exp=00001008", imem_addr_o); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_gnt_i  = 1'b1;
    dec_ready_i = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000 || instr_o !== 32'h5000_1000) begin errors++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/00001000/50001000", i, instr_valid_o, instr_pc_o, instr_o); end
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req%0d got=%b exp=0", i, imem_req_o); end
      if (i < 4) tick();
    end
    dec_ready_i = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1004) begin errors++; $display("FAIL stall_popreq got=%b/%h exp=1/00001004", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_popped got=%b exp=0", instr_valid_o); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_gnt_i = 1'b1;
    lat        = 2;
    tick();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h2000;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (imem_rvalid_i !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rw_wait got=%b/%b exp=1/0", imem_rvalid_i, imem_req_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_dropped got=%b exp=0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin errors++; $display("FAIL rw_newreq got=%b/%h exp=1/00002000", imem_req_o, imem_addr_o); end
    lat = 1;
    tick();
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h2000 || instr_o !== 32'h5000_2000) begin errors++; $display("FAIL rw_instr got=%b/%h/%h exp=1/00002000/50002000", instr_valid_o, instr_pc_o, instr_o); end
  endtask

  task automatic test_redirect_grant();
    do_reset();
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1008) begin errors++; $display("FAIL rg_pre got=%b/%h exp=1/00001008", imem_req_o, imem_addr_o); end
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h3000;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rg_wait got=%b/%b exp=0/0", instr_valid_o, imem_req_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rg_dropped got=%b exp=0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin errors++; $display("FAIL rg_newreq got=%b/%h exp=1/00003000", imem_req_o, imem_addr_o); end
    tick();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h4000;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rv_dropped got=%b exp=0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4000) begin errors++; $display("FAIL rv_newreq got=%b/%h exp=1/00004000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    tick();
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h4FFF_FFFC) begin errors++; $display("FAIL wrap_instr got=%b/%h/%h exp=1/fffffffc/4ffffffc", instr_valid_o, instr_pc_o, instr_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_misalign();
    do_reset();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h2002;
    tick();
    branch_taken_i = 1'b0;
    imem_gnt_i     = 1'b1;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    checks++; if (fetch_misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b/%b exp=1/0", fetch_misalign_o, imem_req_o); end
    tick();
    checks++; if (fetch_misalign_o !== 1'b0) begin errors++; $display("FAIL mis_once got=%b exp=0", fetch_misalign_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_noreq%0d got=%b exp=0", i, imem_req_o); end
    end
`else
    checks++; if (fetch_misalign_o !== 1'b0) begin errors++; $display("FAIL mis_tied got=%b exp=0", fetch_misalign_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin errors++; $display("FAIL mis_align got=%b/%h exp=1/00002000", imem_req_o, imem_addr_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_grant();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
